// File: rtl/sensor_trafico.sv
// Traffic-environment model for the two-street intersection: per-street car queues
// drained while green, sensor outputs, and a sticky checker on the controller's lights.
module sensor_trafico #(
  parameter int QMAX   = 7,
  parameter int DEPART = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       arr_a,
  input  logic       arr_b,
  input  logic [2:0] LA,
  input  logic [2:0] LB,
  output logic       TA,
  output logic       TB,
  output logic [3:0] qa,
  output logic [3:0] qb,
  output logic       ovf,
  output logic       conflict,
  output logic       illegal
);

  localparam logic [2:0] GREEN  = 3'b001;
  localparam logic [2:0] YELLOW = 3'b010;
  localparam logic [2:0] RED    = 3'b100;

  localparam int              TW   = (DEPART > 1) ? $clog2(DEPART) : 1;
  localparam logic [TW-1:0]   TMAX = TW'(DEPART - 1);
  localparam logic [3:0]      QCAP = 4'(QMAX);

  logic [TW-1:0] ta_cnt, tb_cnt;
  logic [2:0]    la_q, lb_q;
  logic          run_a, run_b;
  logic          dep_a, dep_b;
  logic          full_a, full_b;
  logic          lost_a, lost_b;
  logic          bad_code, bad_trans, both_green;

  function automatic logic is_legal(input logic [2:0] l);
    return (l == GREEN) || (l == YELLOW) || (l == RED);
  endfunction

  always_comb begin
    run_a  = (LA == GREEN) && (qa != 4'd0);
    run_b  = (LB == GREEN) && (qb != 4'd0);
    dep_a  = run_a && (ta_cnt == TMAX);
    dep_b  = run_b && (tb_cnt == TMAX);
    full_a = (qa >= QCAP);
    full_b = (qb >= QCAP);
    lost_a = arr_a && !dep_a && full_a;
    lost_b = arr_b && !dep_b && full_b;
    both_green = (LA == GREEN) && (LB == GREEN);
    bad_code   = !is_legal(LA) || !is_legal(LB);
    bad_trans  = ((la_q == GREEN) && (LA == RED)) || ((lb_q == GREEN) && (LB == RED));
  end

  assign TA = (qa != 4'd0);
  assign TB = (qb != 4'd0);

  // Street A: departure timer restarts whenever green or a non-empty queue is lost.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ta_cnt <= '0;
      qa     <= '0;
    end else begin
      if (!run_a || dep_a) ta_cnt <= '0;
      else                 ta_cnt <= ta_cnt + 1'b1;
      if (arr_a && !dep_a && !full_a) qa <= qa + 4'd1;
      else if (dep_a && !arr_a)       qa <= qa - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tb_cnt <= '0;
      qb     <= '0;
    end else begin
      if (!run_b || dep_b) tb_cnt <= '0;
      else                 tb_cnt <= tb_cnt + 1'b1;
      if (arr_b && !dep_b && !full_b) qb <= qb + 4'd1;
      else if (dep_b && !arr_b)       qb <= qb - 4'd1;
    end
  end

  // Previous lights reset to red so the first cycle never looks like green->red.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      la_q     <= RED;
      lb_q     <= RED;
      ovf      <= 1'b0;
      conflict <= 1'b0;
      illegal  <= 1'b0;
    end else begin
      la_q     <= LA;
      lb_q     <= LB;
      ovf      <= ovf | lost_a | lost_b;
      conflict <= conflict | both_green;
      illegal  <= illegal | bad_code | bad_trans;
    end
  end

endmodule

// File: tb/tb_sensor_trafico.sv
// Directed self-checking bench for sensor_trafico (QMAX=7, DEPART=2).
module tb_sensor_trafico;

  logic       clk = 1'b0;
  logic       reset;
  logic       arr_a, arr_b;
  logic [2:0] LA, LB;
  logic       TA, TB;
  logic [3:0] qa, qb;
  logic       ovf, conflict, illegal;

  int assertions = 0;
  int failures   = 0;

  sensor_trafico #(.QMAX(7), .DEPART(2)) dut (
    .clk(clk), .reset(reset), .arr_a(arr_a), .arr_b(arr_b),
    .LA(LA), .LB(LB), .TA(TA), .TB(TB), .qa(qa), .qb(qb),
    .ovf(ovf), .conflict(conflict), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; arr_a = 1'b0; arr_b = 1'b0; LA = 3'b100; LB = 3'b100;
    #3;
    assertions++; if (qa !== 4'd0) begin failures++; $display("FAIL reset_qa: got %0d expected 0", qa); end
    assertions++; if (qb !== 4'd0) begin failures++; $display("FAIL reset_qb: got %0d expected 0", qb); end
    assertions++; if ({TA, TB} !== 2'b00) begin failures++; $display("FAIL reset_sensors: got %b expected 00", {TA, TB}); end
    assertions++; if ({ovf, conflict, illegal} !== 3'b000) begin failures++; $display("FAIL reset_flags: got %b expected 000", {ovf, conflict, illegal}); end
    tick();
    reset = 1'b1;
  endtask

  task automatic test_arrivals();
    arr_a = 1'b1;
    repeat (3) tick();
    arr_a = 1'b0;
    assertions++; if (qa !== 4'd3) begin failures++; $display("FAIL arr_qa: got %0d expected 3", qa); end
    assertions++; if (TA !== 1'b1) begin failures++; $display("FAIL arr_TA: got %b expected 1", TA); end
    assertions++; if ({qb, TB} !== 5'd0) begin failures++; $display("FAIL arr_qb_TB: got %0d/%b expected 0/0", qb, TB); end
    assertions++; if ({ovf, conflict, illegal} !== 3'b000) begin failures++; $display("FAIL arr_flags: got %b expected 000", {ovf, conflict, illegal}); end
  endtask

  task automatic test_departure();
    logic [3:0] exp_q;
    LA = 3'b001;
    for (int i = 1; i <= 6; i++) begin
      tick();
      exp_q = 4'(3 - i / 2);
      assertions++; if (qa !== exp_q) begin failures++; $display("FAIL dep_qa edge %0d: got %0d expected %0d", i, qa, exp_q); end
      assertions++; if (TA !== (exp_q != 4'd0)) begin failures++; $display("FAIL dep_TA edge %0d: got %b expected %b", i, TA, exp_q != 4'd0); end
    end
    LA = 3'b010; tick();
    LA = 3'b100; tick();
    assertions++; if (illegal !== 1'b0) begin failures++; $display("FAIL legal_sequence: got illegal=%b expected 0", illegal); end
  endtask

  task automatic test_overflow();
    arr_b = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i == 7) begin
        assertions++; if ({qb, ovf} !== {4'd7, 1'b0}) begin failures++; $display("FAIL ovf_fill: got qb=%0d ovf=%b expected 7/0", qb, ovf); end
      end
    end
    assertions++; if ({qb, ovf} !== {4'd7, 1'b1}) begin failures++; $display("FAIL ovf_set: got qb=%0d ovf=%b expected 7/1", qb, ovf); end
    arr_b = 1'b0; LB = 3'b001; tick();
    arr_b = 1'b1; tick();
    assertions++; if (qb !== 4'd7) begin failures++; $display("FAIL arr_and_dep: got %0d expected 7", qb); end
    arr_b = 1'b0; tick();
    assertions++; if (qb !== 4'd7) begin failures++; $display("FAIL timer_restart: got %0d expected 7", qb); end
    tick();
    assertions++; if (qb !== 4'd6) begin failures++; $display("FAIL dep_after_full: got %0d expected 6", qb); end
    LB = 3'b010; tick();
    LB = 3'b100; tick();
  endtask

  task automatic test_conflict();
    LA = 3'b001; LB = 3'b001; tick();
    assertions++; if (conflict !== 1'b1) begin failures++; $display("FAIL conflict_set: got %b expected 1", conflict); end
    LA = 3'b010; LB = 3'b010; tick();
    LA = 3'b100; LB = 3'b100; tick();
    assertions++; if ({conflict, illegal} !== 2'b10) begin failures++; $display("FAIL conflict_held: got %b expected 10", {conflict, illegal}); end
  endtask

  task automatic test_illegal_code();
    LA = 3'b011; tick();
    assertions++; if (illegal !== 1'b1) begin failures++; $display("FAIL illegal_code: got %b expected 1", illegal); end
    LA = 3'b100; tick();
  endtask

  task automatic test_green_to_red();
    reset = 1'b0; #1;
    assertions++; if ({ovf, conflict, illegal, qb} !== 7'd0) begin failures++; $display("FAIL reset_clears: got flags=%b qb=%0d expected 000/0", {ovf, conflict, illegal}, qb); end
    tick();
    reset = 1'b1;
    LA = 3'b001; tick();
    assertions++; if (illegal !== 1'b0) begin failures++; $display("FAIL green_hold: got %b expected 0", illegal); end
    LA = 3'b100; tick();
    assertions++; if (illegal !== 1'b1) begin failures++; $display("FAIL green_to_red: got %b expected 1", illegal); end
  endtask

  task automatic test_reset_mid();
    arr_a = 1'b1; tick(); tick(); arr_a = 1'b0;
    LA = 3'b001; tick();
    assertions++; if (qa !== 4'd2) begin failures++; $display("FAIL mid_pre: got %0d expected 2", qa); end
    #2 reset = 1'b0;
    #1;
    assertions++; if ({qa, TA} !== 5'd0) begin failures++; $display("FAIL mid_async: got qa=%0d TA=%b expected 0/0", qa, TA); end
    assertions++; if ({ovf, conflict, illegal} !== 3'b000) begin failures++; $display("FAIL mid_flags: got %b expected 000", {ovf, conflict, illegal}); end
    tick();
    reset = 1'b1;
    arr_a = 1'b1; tick(); arr_a = 1'b0;
    assertions++; if (qa !== 4'd1) begin failures++; $display("FAIL post_arr: got %0d expected 1", qa); end
    tick();
    assertions++; if (qa !== 4'd1) begin failures++; $display("FAIL post_no_early_dep: got %0d expected 1", qa); end
    tick();
    assertions++; if ({qa, TA} !== 5'd0) begin failures++; $display("FAIL post_full_interval: got qa=%0d TA=%b expected 0/0", qa, TA); end
  endtask

  initial begin
    test_reset();
    test_arrivals();
    test_departure();
    test_overflow();
    test_conflict();
    test_illegal_code();
    test_green_to_red();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
